// File: rtl/temp_setpoint_ctrl_if.sv
// Control/feedback bundle between the setpoint controller and its driver/plant.
// The master drives enable, setpoint load and temp feedback; the slave is the controller.
interface temp_setpoint_ctrl_if;
  logic       en;
  logic [6:0] sp_in;
  logic       sp_load;
  logic [6:0] temp;
  logic       inc;
  logic       dec;
  logic [6:0] sp_out;
  logic [1:0] state;
  logic       at_target;
  logic       fault;

  modport master (
    output en, sp_in, sp_load, temp,
    input  inc, dec, sp_out, state, at_target, fault
  );

  modport slave (
    input  en, sp_in, sp_load, temp,
    output inc, dec, sp_out, state, at_target, fault
  );
endinterface

// File: rtl/temp_setpoint_ctrl.sv
// Bang-bang temperature setpoint controller with hysteresis and spaced inc/dec pulses.
// Define TEMP_CTRL_STALL_DETECT_EN to add stall detection (fault on repeated ineffective pulses).
//
// state  | meaning
// IDLE   | disabled or faulted, no pulses
// HEAT   | below band, issuing inc pulses every STEP_GAP+1 cycles
// COOL   | above band, issuing dec pulses every STEP_GAP+1 cycles
// SETTLE | inside band, at_target high
module temp_setpoint_ctrl #(
  parameter int STEP_GAP = 2,
  parameter int HYST     = 2,
  parameter int SP_MIN   = 28,
  parameter int SP_MAX   = 80,
  parameter int SP_RESET = 30
`ifdef TEMP_CTRL_STALL_DETECT_EN
  , parameter int STALL_LIMIT = 4
`endif
) (
  input  logic clk,
  input  logic rst,
  temp_setpoint_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEAT   = 2'd1,
    COOL   = 2'd2,
    SETTLE = 2'd3
  } state_t;

  localparam logic [3:0] GAP4  = 4'(STEP_GAP);
  localparam logic [7:0] HYST8 = 8'(HYST);
  localparam logic [6:0] SPMIN = 7'(SP_MIN);
  localparam logic [6:0] SPMAX = 7'(SP_MAX);

  state_t     state_q, state_d;
  logic [6:0] sp_q, sp_d;
  logic [3:0] gap_q, gap_d;
  logic       inc_q, inc_d, dec_q, dec_d;
  logic [7:0] sp8, temp8, sp_lo, sp_hi;
  logic       stall_trip, fault_hold;

  // Band math is done at 8 bits so sp+HYST cannot wrap and sp-HYST saturates at 0.
  assign sp8   = {1'b0, sp_q};
  assign temp8 = {1'b0, bus.temp};
  assign sp_lo = (sp8 >= HYST8) ? (sp8 - HYST8) : 8'd0;
  assign sp_hi = sp8 + HYST8;

  always_comb begin
    sp_d = sp_q;
    if (bus.sp_load) begin
      if (bus.sp_in < SPMIN)      sp_d = SPMIN;
      else if (bus.sp_in > SPMAX) sp_d = SPMAX;
      else                        sp_d = bus.sp_in;
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    if (!bus.en || fault_hold) begin
      state_d = IDLE;
      gap_d   = 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          gap_d = 4'd0;
          if (temp8 < sp_lo)      state_d = HEAT;
          else if (temp8 > sp_hi) state_d = COOL;
          else                    state_d = SETTLE;
        end
        HEAT: begin
          if (gap_q != 4'd0)      gap_d = gap_q - 4'd1;
          else if (temp8 >= sp8)  state_d = SETTLE;
          else if (stall_trip)    state_d = IDLE;
          else begin
            inc_d = 1'b1;
            gap_d = GAP4;
          end
        end
        COOL: begin
          if (gap_q != 4'd0)      gap_d = gap_q - 4'd1;
          else if (temp8 <= sp8)  state_d = SETTLE;
          else if (stall_trip)    state_d = IDLE;
          else begin
            dec_d = 1'b1;
            gap_d = GAP4;
          end
        end
        SETTLE: begin
          gap_d = 4'd0;
          if (temp8 < sp_lo)      state_d = HEAT;
          else if (temp8 > sp_hi) state_d = COOL;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sp_q    <= 7'(SP_RESET);
      gap_q   <= 4'd0;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      gap_q   <= gap_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
    end
  end

`ifdef TEMP_CTRL_STALL_DETECT_EN
  localparam logic [3:0] STALL_LIM4 = 4'(STALL_LIMIT);

  logic [6:0] temp_lat;
  logic [3:0] stall_cnt;
  logic       pulse_pend, fault_q, en_q;
  logic       decide, same_temp, fault_clr;

  // A decision edge that would otherwise emit another pulse.
  assign decide     = bus.en && !fault_hold && (gap_q == 4'd0) &&
                      (((state_q == HEAT) && (temp8 < sp8)) ||
                       ((state_q == COOL) && (temp8 > sp8)));
  assign same_temp  = pulse_pend && (bus.temp == temp_lat);
  assign stall_trip = decide && same_temp && ((stall_cnt + 4'd1) >= STALL_LIM4);
  assign fault_clr  = fault_q && bus.en && !en_q;
  assign fault_hold = fault_q && !fault_clr;
  assign bus.fault  = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_lat   <= 7'd0;
      stall_cnt  <= 4'd0;
      pulse_pend <= 1'b0;
      fault_q    <= 1'b0;
      en_q       <= 1'b0;
    end else begin
      en_q <= bus.en;
      if (stall_trip)     fault_q <= 1'b1;
      else if (fault_clr) fault_q <= 1'b0;
      if (inc_d || dec_d) begin
        temp_lat   <= bus.temp;
        pulse_pend <= 1'b1;
      end
      if ((state_d != HEAT) && (state_d != COOL)) begin
        stall_cnt  <= 4'd0;
        pulse_pend <= 1'b0;
      end else if (decide) begin
        stall_cnt <= same_temp ? (stall_cnt + 4'd1) : 4'd0;
      end
    end
  end
`else
  assign stall_trip = 1'b0;
  assign fault_hold = 1'b0;
  assign bus.fault  = 1'b0;
`endif

  assign bus.inc       = inc_q;
  assign bus.dec       = dec_q;
  assign bus.sp_out    = sp_q;
  assign bus.state     = state_q;
  assign bus.at_target = (state_q == SETTLE);

endmodule
